// File: rtl/ps2_key_ctrl_if.sv
// Keyboard port bundle: scan-code strobe in from the PS/2 front end, FWFT event FIFO out to the CPU.
// The slave modport is the controller; the master modport is whoever drives bytes and pops events.
interface ps2_key_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    iCODE;
  logic          iCODE_VALID;
  logic          iRD;
  logic          iCLR;
  logic [15:0]   oDATA;
  logic [2:0]    oFLAGS;
  logic          oREADY;
  logic [CW-1:0] oCOUNT;
  logic          oOVF;
  logic          oSHIFT;
  logic [7:0]    oERR_CNT;

  modport master (
    output iCODE, iCODE_VALID, iRD, iCLR,
    input  oDATA, oFLAGS, oREADY, oCOUNT, oOVF, oSHIFT, oERR_CNT
  );

  modport slave (
    input  iCODE, iCODE_VALID, iRD, iCLR,
    output oDATA, oFLAGS, oREADY, oCOUNT, oOVF, oSHIFT, oERR_CNT
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Set-2 scan-code sequencer: E0/F0 prefix FSM, shift tracking, ASCII map, FWFT event FIFO.
// Entry visible 1 cycle after the strobe edge; a push into a full FIFO without a pop is dropped and flagged.
module ps2_key_ctrl #(
  parameter int DEPTH       = 8,
  parameter bit MAKE_ONLY   = 1'b1,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic          iCLK_50,
  input  logic          iRST,
  ps2_key_ctrl_if.slave kb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [23:0] TMO_VAL = 24'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic       shift;
    logic [7:0] code;
    logic [7:0] ascii;
  } entry_t;

  state_t        state, state_nxt;
  logic          vld_q, byte_acc, discard;
  logic          emit, ev_ext, ev_brk, err_inc;
  logic [23:0]   tmo_cnt;
  logic          lshift, rshift, shift_now;
  logic [7:0]    code, ascii;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [7:0]    err_cnt;
  logic          push, pop, full, do_push;

  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic ext, input logic shf);
    logic [7:0] a;
    a = 8'h00;
    if (ext) begin
      if (c == 8'h5A) a = 8'h0D;
    end else begin
      case (c)
        8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d"; 8'h24: a = "e";
        8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h"; 8'h43: a = "i"; 8'h3B: a = "j";
        8'h42: a = "k"; 8'h4B: a = "l"; 8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o";
        8'h4D: a = "p"; 8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
        8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x"; 8'h35: a = "y";
        8'h1A: a = "z";
        8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3"; 8'h25: a = "4";
        8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7"; 8'h3E: a = "8"; 8'h46: a = "9";
        8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
        default: a = 8'h00;
      endcase
      if (shf && a >= "a" && a <= "z") a = a - 8'h20;
    end
    return a;
  endfunction

  assign code      = kb.iCODE;
  assign byte_acc  = kb.iCODE_VALID & ~vld_q;
  assign discard   = code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  assign shift_now = lshift | rshift;
  assign ascii     = ev_brk ? 8'h00 : to_ascii(code, ev_ext, shift_now);

  always_ff @(posedge iCLK_50) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    err_inc   = 1'b0;
    if (byte_acc) begin
      case (state)
        IDLE: begin
          if (code == 8'hE0)      state_nxt = GOT_E0;
          else if (code == 8'hF0) state_nxt = GOT_F0;
          else if (!discard)      emit = 1'b1;
        end
        GOT_E0: begin
          if (code == 8'hF0)      state_nxt = GOT_E0F0;
          else if (code == 8'hE0) state_nxt = GOT_E0;
          else begin
            state_nxt = IDLE;
            err_inc   = discard;
            emit      = ~discard;
            ev_ext    = 1'b1;
          end
        end
        default: begin
          // GOT_F0 / GOT_E0F0: next byte completes a break unless it is a prefix or noise
          state_nxt = IDLE;
          err_inc   = discard | (code == 8'hE0) | (code == 8'hF0);
          emit      = ~err_inc;
          ev_ext    = (state == GOT_E0F0);
          ev_brk    = 1'b1;
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_VAL) begin
      state_nxt = IDLE;
      err_inc   = 1'b1;
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      vld_q   <= 1'b0;
      tmo_cnt <= '0;
      lshift  <= 1'b0;
      rshift  <= 1'b0;
    end else begin
      vld_q   <= kb.iCODE_VALID;
      tmo_cnt <= (byte_acc || state_nxt == IDLE) ? '0 : tmo_cnt + 24'd1;
      if (emit && !ev_ext) begin
        if (code == 8'h12) lshift <= ~ev_brk;
        if (code == 8'h59) rshift <= ~ev_brk;
      end
    end
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = kb.iRD && (count != '0);
  assign push    = emit && !(ev_brk && MAKE_ONLY);
  assign do_push = push && (!full || pop);

  always_ff @(posedge iCLK_50) begin
    if (do_push) mem[wr_ptr] <= '{brk: ev_brk, ext: ev_ext, shift: shift_now, code: code, ascii: ascii};
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
      if (push && full && !pop) ovf <= 1'b1;
      else if (kb.iCLR)         ovf <= 1'b0;
      if (err_inc) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (kb.iCLR) begin
        err_cnt <= '0;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign kb.oDATA    = {head.code, head.ascii};
  assign kb.oFLAGS   = {head.brk, head.ext, head.shift};
  assign kb.oREADY   = (count != '0);
  assign kb.oCOUNT   = count;
  assign kb.oOVF     = ovf;
  assign kb.oSHIFT   = shift_now;
  assign kb.oERR_CNT = err_cnt;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: a MAKE_ONLY=1 and a MAKE_ONLY=0 instance share one byte stream,
// each checked against a queue-based reference model after every clock edge that matters.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] code;
  logic vld, rd, clr;

  always #10 clk = ~clk;

  ps2_key_ctrl_if #(.DEPTH(DEPTH)) if_m ();
  ps2_key_ctrl_if #(.DEPTH(DEPTH)) if_a ();

  assign if_m.iCODE = code;  assign if_m.iCODE_VALID = vld;  assign if_m.iRD = rd;  assign if_m.iCLR = clr;
  assign if_a.iCODE = code;  assign if_a.iCODE_VALID = vld;  assign if_a.iRD = rd;  assign if_a.iCLR = clr;

  ps2_key_ctrl #(.DEPTH(DEPTH), .MAKE_ONLY(1'b1), .TIMEOUT_CYC(TMO)) u_dut_m (.iCLK_50(clk), .iRST(rst), .kb(if_m));
  ps2_key_ctrl #(.DEPTH(DEPTH), .MAKE_ONLY(1'b0), .TIMEOUT_CYC(TMO)) u_dut_a (.iCLK_50(clk), .iRST(rst), .kb(if_a));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: queued entries {brk,ext,shift,code,ascii}, pending prefixes, modifiers
  logic [18:0] q_m[$];
  logic [18:0] q_a[$];
  bit ovf_m, ovf_a, p_e0, p_f0, lsh, rsh;
  int err;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] noise [6]      = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  function automatic logic [7:0] exp_ascii(input logic [7:0] b, input bit ext, input bit brk, input bit shf);
    if (brk) return 8'h00;
    if (ext) return (b == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++) if (let_codes[i] == b) return (shf ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == b) return 8'h30 + 8'(i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  function automatic bit is_noise(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (noise[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic bump_err();
    if (err < 255) err++;
  endtask

  task automatic model_edge(input bit has_byte, input logic [7:0] b, input bit do_rd);
    bit full_m, full_a, pm, pa, em, ext, brk, sh;
    logic [18:0] ent;
    full_m = (q_m.size() == DEPTH);
    full_a = (q_a.size() == DEPTH);
    pm = do_rd && q_m.size() > 0;
    pa = do_rd && q_a.size() > 0;
    if (pm) void'(q_m.pop_front());
    if (pa) void'(q_a.pop_front());
    em = 0; ext = 0; brk = 0;
    if (has_byte) begin
      if (!p_e0 && !p_f0) begin
        if (b == 8'hE0)      p_e0 = 1;
        else if (b == 8'hF0) p_f0 = 1;
        else if (!is_noise(b)) em = 1;
      end else if (p_f0) begin
        if (b == 8'hE0 || b == 8'hF0 || is_noise(b)) bump_err();
        else begin em = 1; ext = p_e0; brk = 1; end
        p_e0 = 0; p_f0 = 0;
      end else begin
        if (b == 8'hF0) p_f0 = 1;
        else if (b != 8'hE0) begin
          if (is_noise(b)) bump_err();
          else begin em = 1; ext = 1; end
          p_e0 = 0;
        end
      end
    end
    if (em) begin
      sh  = lsh | rsh;
      ent = {brk, ext, sh, b, exp_ascii(b, ext, brk, sh)};
      if (!ext && b == 8'h12) lsh = !brk;
      if (!ext && b == 8'h59) rsh = !brk;
      if (!brk) begin
        if (!full_m || pm) q_m.push_back(ent); else ovf_m = 1;
      end
      if (!full_a || pa) q_a.push_back(ent); else ovf_a = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":m_ready"}, 32'(if_m.oREADY), 32'(q_m.size() != 0));
    chk({tag, ":m_count"}, 32'(if_m.oCOUNT), 32'(q_m.size()));
    chk({tag, ":m_ovf"},   32'(if_m.oOVF),   32'(ovf_m));
    chk({tag, ":a_count"}, 32'(if_a.oCOUNT), 32'(q_a.size()));
    chk({tag, ":a_ovf"},   32'(if_a.oOVF),   32'(ovf_a));
    chk({tag, ":shift"},   32'(if_m.oSHIFT), 32'(lsh | rsh));
    chk({tag, ":err"},     32'(if_m.oERR_CNT), 32'(err));
    chk({tag, ":a_err"},   32'(if_a.oERR_CNT), 32'(err));
    if (q_m.size() > 0) begin
      chk({tag, ":m_data"},  32'(if_m.oDATA),  32'(q_m[0][15:0]));
      chk({tag, ":m_flags"}, 32'(if_m.oFLAGS), 32'(q_m[0][18:16]));
    end
    if (q_a.size() > 0) begin
      chk({tag, ":a_data"},  32'(if_a.oDATA),  32'(q_a[0][15:0]));
      chk({tag, ":a_flags"}, 32'(if_a.oFLAGS), 32'(q_a[0][18:16]));
    end
  endtask

  // Called at a negedge; the strobe rises for `hold` cycles, then one low cycle
  task automatic send(input logic [7:0] b, input int hold, input bit rd_same);
    code = b; vld = 1'b1; rd = rd_same;
    @(negedge clk);
    model_edge(1'b1, b, rd_same);
    rd = 1'b0;
    check_all("byte");
    for (int i = 1; i < hold; i++) @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop1();
    rd = 1'b1;
    @(negedge clk);
    model_edge(1'b0, 8'h00, 1'b1);
    rd = 1'b0;
    check_all("pop");
  endtask

  task automatic drain();
    while (q_m.size() > 0 || q_a.size() > 0) pop1();
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ovf_m = 0; ovf_a = 0; err = 0;
    check_all("clr");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n > TMO + 1 && (p_e0 || p_f0)) begin
      bump_err();
      p_e0 = 0; p_f0 = 0;
    end
    check_all("idle");
  endtask

  task automatic do_reset();
    rst = 1'b1; code = 8'h00; vld = 1'b0; rd = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q_m.delete(); q_a.delete();
    ovf_m = 0; ovf_a = 0; p_e0 = 0; p_f0 = 0; lsh = 0; rsh = 0; err = 0;
    @(negedge clk);
    check_all("reset");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] b;
    do_reset();
    chk("reset_ready", 32'(if_m.oREADY), 32'd0);

    // Plain make with one-cycle latency
    send(8'h1C, 1, 1'b0);
    chk("t1_data",  32'(if_m.oDATA),  32'h1C61);
    chk("t1_flags", 32'(if_m.oFLAGS), 32'd0);
    drain();

    // Shift make/break around a letter
    send(8'h12, 1, 0); send(8'h1C, 1, 0); send(8'hF0, 1, 0); send(8'h1C, 1, 0);
    send(8'hF0, 1, 0); send(8'h12, 1, 0);
    chk("t2_head0",  32'(if_m.oDATA),  32'h1200);
    chk("t2_flags0", 32'(if_m.oFLAGS), 32'd0);
    chk("t2_count",  32'(if_m.oCOUNT), 32'd2);
    pop1();
    chk("t2_head1",  32'(if_m.oDATA),  32'h1C41);
    chk("t2_flags1", 32'(if_m.oFLAGS), 32'b001);
    chk("t2_shift",  32'(if_m.oSHIFT), 32'd0);
    drain();

    // Extended make and break, break retained when MAKE_ONLY=0
    send(8'hE0, 1, 0); send(8'h75, 1, 0); send(8'hE0, 1, 0); send(8'hF0, 1, 0); send(8'h75, 1, 0);
    chk("t3_head0",  32'(if_a.oDATA),  32'h7500);
    chk("t3_flags0", 32'(if_a.oFLAGS), 32'b010);
    pop1();
    chk("t3_head1",  32'(if_a.oDATA),  32'h7500);
    chk("t3_flags1", 32'(if_a.oFLAGS), 32'b110);
    drain();

    // Long strobe yields one byte
    send(8'h16, 5, 0);
    chk("t4_count", 32'(if_a.oCOUNT), 32'd1);
    chk("t4_data",  32'(if_a.oDATA),  32'h1631);
    drain();

    // Overflow, push+pop when full, then clear
    for (int i = 0; i < 9; i++) send(let_codes[i], 1, 0);
    chk("t5_count", 32'(if_m.oCOUNT), 32'd8);
    chk("t5_ovf",   32'(if_m.oOVF),   32'd1);
    chk("t5_head",  32'(if_m.oDATA),  32'h1C61);
    send(let_codes[9], 1, 1'b1);
    chk("t5_pp_count", 32'(if_m.oCOUNT), 32'd8);
    clear_flags();
    chk("t5_clr", 32'(if_m.oOVF), 32'd0);
    drain();

    // Prefix timeout: following byte is a fresh make
    send(8'hF0, 1, 0);
    idle(3 * TMO);
    send(8'h1C, 1, 0);
    chk("t6_err",   32'(if_m.oERR_CNT), 32'd1);
    chk("t6_data",  32'(if_a.oDATA),    32'h1C61);
    chk("t6_flags", 32'(if_a.oFLAGS),   32'd0);
    drain();

    // Randomized byte stream with interleaved pops and clears
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r < 7)       b = let_codes[$urandom_range(0, 25)];
      else if (r < 9)  b = dig_codes[$urandom_range(0, 9)];
      else if (r < 11) b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      else if (r < 13) b = 8'hE0;
      else if (r < 16) b = 8'hF0;
      else if (r < 17) b = noise[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      send(b, $urandom_range(1, 3), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) pop1();
      if ($urandom_range(0, 59) == 0) clear_flags();
      if ($urandom_range(0, 79) == 0) idle(2 * TMO);
    end
    drain();

    // Reset mid-sequence drops the prefix and the queue
    send(8'h1C, 1, 0); send(8'hF0, 1, 0);
    do_reset();
    send(8'h75, 1, 0);
    chk("t7_data",  32'(if_m.oDATA),  32'h7500);
    chk("t7_flags", 32'(if_m.oFLAGS), 32'd0);
    chk("t7_count", 32'(if_m.oCOUNT), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Scan-code sequencer and buffer between the PS/2 receive front end and the pipeline CPU's keyboard port. It consumes raw set-2 bytes, one per strobe, and runs the E0/F0 prefix state machine. It tracks the shift modifiers, translates make codes to ASCII and queues completed key events in a FIFO. The CPU pops that FIFO through a read handshake.

## Interface
- DEPTH, 8 — FIFO entries; power of two, ≥2.
- MAKE_ONLY, 1 — 1: break events update modifiers but are not queued; 0: break events are queued too.
- TIMEOUT_CYC, 2500000 — cycles a prefix state may wait for its next byte (50 ms at 50 MHz); 24-bit counter.
- iCLK_50  in  1  system clock; single clock domain; all logic on rising edge.
- iRST  in  1  reset; synchronous, active-high.
- iCODE  in  8  raw scan-code byte; stable while iCODE_VALID is high.
- iCODE_VALID  in  1  byte strobe; any width ≥1 cycle; one byte per 0→1 transition.
- iRD  in  1  pop request; one entry per cycle it is high and oREADY=1.
- iCLR  in  1  clears oOVF and oERR_CNT.
- oDATA  out  16  FIFO head {code[7:0], ascii[7:0]}; first-word fall-through; valid when oREADY=1.
- oFLAGS  out  3  FIFO head {brk, ext, shift}.
- oREADY  out  1  FIFO not empty.
- oCOUNT  out  log2(DEPTH)+1  current occupancy.
- oOVF  out  1  sticky; an event was dropped because the FIFO was full.
- oSHIFT  out  1  live shift state (left OR right held).
- oERR_CNT  out  8  saturating protocol-error count.

## Operation
- Strobe edge detect: register the previous iCODE_VALID. A byte is accepted at an edge where iCODE_VALID=1 and the previous sample=0.
- Discard set: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF. These are never queued.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- IDLE:
  - E0 → GOT_E0.
  - F0 → GOT_F0.
  - Discard-set byte → IDLE, no error.
  - Any other byte → emit(ext=0, brk=0).
- GOT_E0:
  - F0 → GOT_E0F0.
  - E0 → stay.
  - Any other byte → emit(ext=1, brk=0), go to IDLE.
- GOT_F0: any valid byte → emit(ext=0, brk=1), go to IDLE.
- GOT_E0F0: any valid byte → emit(ext=1, brk=1), go to IDLE.
- Error cases, each → IDLE with no emit and oERR_CNT+1 (saturates at 0xFF):
  - In GOT_F0 or GOT_E0F0, the byte is E0 or F0.
  - In any prefix state, the byte is from the discard set.
- Timeout: in a prefix state, a cycle counter resets on every accepted byte. When it reaches TIMEOUT_CYC → IDLE and oERR_CNT+1.
- Modifiers: non-extended 0x12 (left) and 0x59 (right) set their flag on make and clear it on break. Extended E0 12 is ignored for shift.
- Entry shift bit and ASCII shift use the shift state before the current event.
- ASCII translation (non-extended makes; lowercase, uppercase when shift=1):
  - a=1C b=32 c=21 d=23 e=24 f=2B g=34 h=33 i=43 j=3B k=42 l=4B m=3A n=31 o=44 p=4D q=15 r=2D s=1B t=2C u=3C v=2A w=1D x=22 y=35 z=1A.
  - 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46; digits ignore shift.
  - 29→0x20, 5A→0x0D, 66→0x08. Extended E0 5A→0x0D.
  - Everything else, and all break events, → ascii 0x00.
- Emit pushes {brk, ext, shift, code, ascii} unless brk=1 and MAKE_ONLY=1.
- FIFO:
  - Push when full (no simultaneous pop) drops the event and sets oOVF.
  - Push and pop in the same cycle while full both succeed, with no drop.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- iCLR in the same cycle as a new overflow or error: the set or increment wins.

## Timing
- Reset values: FSM=IDLE, both shift flags 0, FIFO empty, oREADY=0, oCOUNT=0, oOVF=0, oERR_CNT=0, edge register 0, timeout counter 0. oDATA/oFLAGS = current head RAM slot (don't-care while oREADY=0).
- Accepted byte at edge k: the FSM, modifiers and FIFO write all update at edge k. oREADY/oDATA reflect the entry after edge k (1-cycle latency from the strobe being sampled).
- Pop at edge k: the next head appears after edge k.
- Back-to-back strobes need ≥1 low cycle between bytes.
- iRST mid-sequence: the prefix is discarded and queued entries are lost.

## Test plan
- IDLE, byte 1C → entry oDATA=0x1C61, oFLAGS=000, oREADY=1 one cycle after the strobe edge.
- Bytes 12, 1C, F0 1C, F0 12 with MAKE_ONLY=1 → queue: 0x1200 flags 000; 0x1C41 flags 001. oSHIFT ends 0.
- Bytes E0 75, E0 F0 75 with MAKE_ONLY=0 → 0x7500 flags 010; 0x7500 flags 110.
- Strobe held high 5 cycles carrying 16 → exactly one entry 0x1631.
- 9 makes into DEPTH=8 with no pops → oCOUNT=8, oOVF=1, head=first byte. Then iRD and a push in the same cycle → oCOUNT stays 8. Then iCLR → oOVF=0.
- F0 followed by an idle period > TIMEOUT_CYC, then 1C → oERR_CNT=1, entry 0x1C61 flags 000 (a make, not a break).
